// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg: shared types, sizes and operand-lookup helper for the reorder buffer
package reorder_buffer_pkg;
  localparam int ROB_POS_W = 4;
  localparam int ROB_DEPTH = 1 << ROB_POS_W;
  typedef enum logic [1:0] {
    ROB_REG   = 2'd0,
    ROB_BR    = 2'd1,
    ROB_STORE = 2'd2,
    ROB_JALR  = 2'd3
  } rob_type_e;
  // Static part of an entry; the result value lives in a separate array so
  // writebacks never touch the issue-time fields.
  typedef struct packed {
    rob_type_e   typ;
    logic [4:0]  rd;
    logic        pred;
    logic [31:0] aux;
  } rob_entry_t;
  // Operand lookup: committed-ready entry first, then same-cycle ALU, then load.
  function automatic logic [32:0] rob_lookup(input logic stored, input logic [31:0] sval,
                                             input logic alu_hit, input logic [31:0] alu_val,
                                             input logic ld_hit, input logic [31:0] ld_val);
    return stored ? {1'b1, sval} : alu_hit ? {1'b1, alu_val} : ld_hit ? {1'b1, ld_val} : 33'd0;
  endfunction
endpackage

// File: rtl/reorder_buffer.sv
// reorder_buffer: 16-entry circular ROB with in-order single commit and flush on misprediction
// Ports:
//   clk, rst (sync active-high), rdy (global enable, low holds all state)
//   issue_*            : allocate at tail, issue_pos returns the tail index, rob_full when count==ROB_SIZE
//   ALU_* / update_LSB_Load_* : value writebacks, store_ready_* : store resolved (ready only)
//   query_pos1/2 -> query_ready1/2, query_val1/2 : combinational operand lookup with forwarding
//   commit_*           : registered commit pulse for REG/JALR, commit_store for stores
//   jump_wrong/jump_pc : registered flush pulse and redirect target
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int POS_W    = ROB_POS_W,
  parameter int ROB_SIZE = 1 << POS_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             issue_valid,
  input  logic [1:0]       issue_type,
  input  logic [4:0]       issue_rd,
  input  logic             issue_pred_taken,
  input  logic [31:0]      issue_aux,
  output logic [POS_W-1:0] issue_pos,
  output logic             rob_full,
  input  logic             ALU_instr_valid,
  input  logic [POS_W-1:0] ALU_ROB_pos,
  input  logic [31:0]      ALU_val,
  input  logic             update_LSB_Load_valid,
  input  logic [POS_W-1:0] update_LSB_Load_ROB_pos,
  input  logic [31:0]      update_LSB_Load_val,
  input  logic             store_ready_valid,
  input  logic [POS_W-1:0] store_ready_pos,
  input  logic [POS_W-1:0] query_pos1,
  input  logic [POS_W-1:0] query_pos2,
  output logic             query_ready1,
  output logic             query_ready2,
  output logic [31:0]      query_val1,
  output logic [31:0]      query_val2,
  output logic             commit_valid,
  output logic [POS_W-1:0] commit_ROB_pos,
  output logic [4:0]       commit_rd,
  output logic [31:0]      commit_val,
  output logic             commit_store,
  output logic             jump_wrong,
  output logic [31:0]      jump_pc
);
  localparam logic [POS_W:0] FULL = (POS_W+1)'(ROB_SIZE);
  logic [POS_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [POS_W:0] count_q, count_d;
  logic [ROB_SIZE-1:0] busy_q, ready_q;
  rob_entry_t ent_q [ROB_SIZE];
  logic [ROB_SIZE-1:0][31:0] val_q;
  logic commit_valid_q, commit_valid_d, commit_store_q, commit_store_d, jump_wrong_q, jump_wrong_d;
  logic [POS_W-1:0] commit_pos_q, commit_pos_d;
  logic [4:0] commit_rd_q, commit_rd_d;
  logic [31:0] commit_val_q, commit_val_d, jump_pc_q, jump_pc_d;
  logic do_issue, do_commit, flush, wb_alu, wb_ld, wb_st, is_jalr;
  rob_entry_t head_ent;
  logic [31:0] head_val;
  assign rob_full = count_q == FULL;
  assign issue_pos = tail_q;
  assign {query_ready1, query_val1} = rob_lookup(busy_q[query_pos1] && ready_q[query_pos1], val_q[query_pos1],
    ALU_instr_valid && ALU_ROB_pos == query_pos1, ALU_val,
    update_LSB_Load_valid && update_LSB_Load_ROB_pos == query_pos1, update_LSB_Load_val);
  assign {query_ready2, query_val2} = rob_lookup(busy_q[query_pos2] && ready_q[query_pos2], val_q[query_pos2],
    ALU_instr_valid && ALU_ROB_pos == query_pos2, ALU_val,
    update_LSB_Load_valid && update_LSB_Load_ROB_pos == query_pos2, update_LSB_Load_val);
  assign commit_valid   = commit_valid_q;
  assign commit_ROB_pos = commit_pos_q;
  assign commit_rd      = commit_rd_q;
  assign commit_val     = commit_val_q;
  assign commit_store   = commit_store_q;
  assign jump_wrong     = jump_wrong_q;
  assign jump_pc        = jump_pc_q;
  always_comb begin
    head_ent = ent_q[head_q];
    head_val = val_q[head_q];
    is_jalr = head_ent.typ == ROB_JALR;
    do_issue = issue_valid && !rob_full && rdy && !jump_wrong_q;
    // Commit looks only at registered ready, so a writeback to head commits a cycle later.
    do_commit = busy_q[head_q] && ready_q[head_q] && rdy && !jump_wrong_q;
    flush = do_commit && (is_jalr || (head_ent.typ == ROB_BR && head_val[0] != head_ent.pred));
    wb_alu = ALU_instr_valid && rdy && !jump_wrong_q && busy_q[ALU_ROB_pos];
    wb_ld = update_LSB_Load_valid && rdy && !jump_wrong_q && busy_q[update_LSB_Load_ROB_pos];
    wb_st = store_ready_valid && rdy && !jump_wrong_q && busy_q[store_ready_pos];
    head_d = flush ? '0 : head_q + POS_W'(do_commit);
    tail_d = flush ? '0 : tail_q + POS_W'(do_issue);
    count_d = flush ? '0 : count_q + (POS_W+1)'(do_issue) - (POS_W+1)'(do_commit);
    commit_valid_d = do_commit && (head_ent.typ == ROB_REG || is_jalr);
    commit_pos_d = do_commit ? head_q : '0;
    commit_rd_d = commit_valid_d ? head_ent.rd : '0;
    commit_val_d = !commit_valid_d ? '0 : is_jalr ? head_ent.aux : head_val;
    commit_store_d = do_commit && head_ent.typ == ROB_STORE;
    jump_wrong_d = flush;
    jump_pc_d = !flush ? '0 : is_jalr ? head_val : head_ent.aux;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      busy_q <= '0;
      ready_q <= '0;
      commit_valid_q <= 1'b0;
      commit_pos_q <= '0;
      commit_rd_q <= '0;
      commit_val_q <= '0;
      commit_store_q <= 1'b0;
      jump_wrong_q <= 1'b0;
      jump_pc_q <= '0;
    end else if (rdy) begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      commit_valid_q <= commit_valid_d;
      commit_pos_q <= commit_pos_d;
      commit_rd_q <= commit_rd_d;
      commit_val_q <= commit_val_d;
      commit_store_q <= commit_store_d;
      jump_wrong_q <= jump_wrong_d;
      jump_pc_q <= jump_pc_d;
      if (flush) begin
        busy_q <= '0;
        ready_q <= '0;
      end else begin
        if (wb_alu) ready_q[ALU_ROB_pos] <= 1'b1;
        if (wb_ld) ready_q[update_LSB_Load_ROB_pos] <= 1'b1;
        if (wb_st) ready_q[store_ready_pos] <= 1'b1;
        if (do_commit) busy_q[head_q] <= 1'b0;
        if (do_issue) begin
          busy_q[tail_q] <= 1'b1;
          ready_q[tail_q] <= 1'b0;
        end
      end
    end
  end
  // Payload storage needs no reset: busy/ready gate every use of it.
  always_ff @(posedge clk) begin
    if (do_issue) ent_q[tail_q] <= '{typ: rob_type_e'(issue_type), rd: issue_rd, pred: issue_pred_taken, aux: issue_aux};
    if (wb_alu) val_q[ALU_ROB_pos] <= ALU_val;
    if (wb_ld) val_q[update_LSB_Load_ROB_pos] <= update_LSB_Load_val;
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed table and hand-written sequences checking the reorder buffer
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;
  logic clk = 1'b0, rst = 1'b1, rdy = 1'b1;
  logic issue_valid = 1'b0, issue_pred_taken = 1'b0;
  logic [1:0] issue_type = 2'd0;
  logic [4:0] issue_rd = 5'd0;
  logic [31:0] issue_aux = 32'd0;
  logic [3:0] issue_pos;
  logic rob_full;
  logic alu_v = 1'b0, ld_v = 1'b0, st_v = 1'b0;
  logic [3:0] alu_pos = 4'd0, ld_pos = 4'd0, st_pos = 4'd0, q1 = 4'd0, q2 = 4'd0;
  logic [31:0] alu_val = 32'd0, ld_val = 32'd0;
  logic qr1, qr2, commit_valid, commit_store, jump_wrong;
  logic [31:0] qv1, qv2, commit_val, jump_pc;
  logic [3:0] commit_ROB_pos;
  logic [4:0] commit_rd;
  int n_cmp = 0, n_bad = 0;

  reorder_buffer dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
    .issue_pred_taken(issue_pred_taken), .issue_aux(issue_aux),
    .issue_pos(issue_pos), .rob_full(rob_full),
    .ALU_instr_valid(alu_v), .ALU_ROB_pos(alu_pos), .ALU_val(alu_val),
    .update_LSB_Load_valid(ld_v), .update_LSB_Load_ROB_pos(ld_pos), .update_LSB_Load_val(ld_val),
    .store_ready_valid(st_v), .store_ready_pos(st_pos),
    .query_pos1(q1), .query_pos2(q2),
    .query_ready1(qr1), .query_ready2(qr2), .query_val1(qv1), .query_val2(qv2),
    .commit_valid(commit_valid), .commit_ROB_pos(commit_ROB_pos), .commit_rd(commit_rd),
    .commit_val(commit_val), .commit_store(commit_store),
    .jump_wrong(jump_wrong), .jump_pc(jump_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic iv; logic [1:0] it; logic [4:0] rd;
    logic av; logic [3:0] ap; logic [31:0] aval; logic [3:0] q1;
    logic [3:0] e_pos; logic e_qr; logic [31:0] e_qv;
    logic e_cv; logic [3:0] e_cp; logic [4:0] e_crd; logic [31:0] e_cval;
  } vec_t;
  vec_t v [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    issue_valid = 1'b0; alu_v = 1'b0; ld_v = 1'b0; st_v = 1'b0;
  endtask
  task automatic issue(input logic [1:0] t, input logic [4:0] rd, input logic pt, input logic [31:0] aux);
    issue_valid = 1'b1; issue_type = t; issue_rd = rd; issue_pred_taken = pt; issue_aux = aux;
  endtask
  task automatic alu(input logic [3:0] p, input logic [31:0] val);
    alu_v = 1'b1; alu_pos = p; alu_val = val;
  endtask
  task automatic load(input logic [3:0] p, input logic [31:0] val);
    ld_v = 1'b1; ld_pos = p; ld_val = val;
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_cv"}, 32'(commit_valid), 32'd0);
    check({tag, "_cs"}, 32'(commit_store), 32'd0);
    check({tag, "_jw"}, 32'(jump_wrong), 32'd0);
    check({tag, "_jpc"}, jump_pc, 32'd0);
    check({tag, "_cval"}, commit_val, 32'd0);
    check({tag, "_crd"}, 32'(commit_rd), 32'd0);
    check({tag, "_cpos"}, 32'(commit_ROB_pos), 32'd0);
    check({tag, "_ipos"}, 32'(issue_pos), 32'd0);
    check({tag, "_full"}, 32'(rob_full), 32'd0);
  endtask
  task automatic do_reset();
    idle(); rdy = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    v[0] = '{1'b1, ROB_REG, 5'd1, 1'b0, 4'd0, 32'h0, 4'd0, 4'd0, 1'b0, 32'h0, 1'b0, 4'd0, 5'd0, 32'h0};
    v[1] = '{1'b1, ROB_REG, 5'd2, 1'b0, 4'd0, 32'h0, 4'd0, 4'd1, 1'b0, 32'h0, 1'b0, 4'd0, 5'd0, 32'h0};
    v[2] = '{1'b1, ROB_REG, 5'd3, 1'b0, 4'd0, 32'h0, 4'd0, 4'd2, 1'b0, 32'h0, 1'b0, 4'd0, 5'd0, 32'h0};
    v[3] = '{1'b0, ROB_REG, 5'd0, 1'b1, 4'd2, 32'hA, 4'd2, 4'd3, 1'b1, 32'hA, 1'b0, 4'd0, 5'd0, 32'h0};
    v[4] = '{1'b0, ROB_REG, 5'd0, 1'b1, 4'd0, 32'hB, 4'd2, 4'd3, 1'b1, 32'hA, 1'b0, 4'd0, 5'd0, 32'h0};
    v[5] = '{1'b0, ROB_REG, 5'd0, 1'b1, 4'd1, 32'hC, 4'd0, 4'd3, 1'b1, 32'hB, 1'b1, 4'd0, 5'd1, 32'hB};
    v[6] = '{1'b0, ROB_REG, 5'd0, 1'b0, 4'd0, 32'h0, 4'd1, 4'd3, 1'b1, 32'hC, 1'b1, 4'd1, 5'd2, 32'hC};
    v[7] = '{1'b0, ROB_REG, 5'd0, 1'b0, 4'd0, 32'h0, 4'd2, 4'd3, 1'b1, 32'hA, 1'b1, 4'd2, 5'd3, 32'hA};
    v[8] = '{1'b0, ROB_REG, 5'd0, 1'b0, 4'd0, 32'h0, 4'd2, 4'd3, 1'b0, 32'h0, 1'b0, 4'd0, 5'd0, 32'h0};

    // Reset state
    tick(); tick();
    do_reset();
    check_zero("reset");

    // In-order commit of out-of-order ALU results
    for (int i = 0; i < 9; i++) begin
      idle();
      issue_valid = v[i].iv; issue_type = v[i].it; issue_rd = v[i].rd;
      alu_v = v[i].av; alu_pos = v[i].ap; alu_val = v[i].aval; q1 = v[i].q1;
      #1;
      check($sformatf("tbl%0d_ipos", i), 32'(issue_pos), 32'(v[i].e_pos));
      check($sformatf("tbl%0d_qr1", i), 32'(qr1), 32'(v[i].e_qr));
      check($sformatf("tbl%0d_qv1", i), qv1, v[i].e_qv);
      tick();
      check($sformatf("tbl%0d_cv", i), 32'(commit_valid), 32'(v[i].e_cv));
      if (v[i].e_cv) begin
        check($sformatf("tbl%0d_cpos", i), 32'(commit_ROB_pos), 32'(v[i].e_cp));
        check($sformatf("tbl%0d_crd", i), 32'(commit_rd), 32'(v[i].e_crd));
        check($sformatf("tbl%0d_cval", i), commit_val, v[i].e_cval);
      end
    end

    // Fill to 16, ignored 17th issue, wrap after one commit
    do_reset();
    for (int i = 0; i < 16; i++) begin
      idle(); issue(ROB_REG, 5'(i), 1'b0, 32'd0);
      #1;
      check("fill_pos", 32'(issue_pos), 32'(i));
      tick();
    end
    idle(); #1;
    check("full_after16", 32'(rob_full), 32'd1);
    issue(ROB_REG, 5'd20, 1'b0, 32'd0);
    tick();
    idle(); #1;
    check("full_17th_ignored", 32'(rob_full), 32'd1);
    check("pos_17th_ignored", 32'(issue_pos), 32'd0);
    alu(4'd0, 32'h77);
    tick();
    idle();
    tick();
    check("wrap_cv", 32'(commit_valid), 32'd1);
    check("wrap_cval", commit_val, 32'h77);
    check("wrap_crd", 32'(commit_rd), 32'd0);
    check("wrap_full_clear", 32'(rob_full), 32'd0);
    check("wrap_ipos", 32'(issue_pos), 32'd0);
    issue(ROB_REG, 5'd9, 1'b0, 32'd0);
    tick();
    idle(); #1;
    check("refull", 32'(rob_full), 32'd1);
    alu(4'd1, 32'h11); load(4'd2, 32'h22); q1 = 4'd2; q2 = 4'd1;
    #1;
    check("fwd_ld_qr1", 32'(qr1), 32'd1);
    check("fwd_ld_qv1", qv1, 32'h22);
    check("fwd_alu_qr2", 32'(qr2), 32'd1);
    check("fwd_alu_qv2", qv2, 32'h11);
    tick();
    idle(); alu(4'd3, 32'h33); load(4'd3, 32'h44); q1 = 4'd3;
    #1;
    check("fwd_alu_prio", qv1, 32'h33);
    tick();
    check("dual_c1_pos", 32'(commit_ROB_pos), 32'd1);
    check("dual_c1_val", commit_val, 32'h11);
    idle();
    tick();
    check("dual_c2_pos", 32'(commit_ROB_pos), 32'd2);
    check("dual_c2_val", commit_val, 32'h22);

    // Mispredicted branch flushes younger entries
    do_reset();
    issue(ROB_BR, 5'd0, 1'b0, 32'h100);
    tick();
    idle(); issue(ROB_REG, 5'd5, 1'b0, 32'd0); alu(4'd0, 32'd1);
    tick();
    idle(); issue(ROB_REG, 5'd6, 1'b0, 32'd0);
    tick();
    check("br_jw", 32'(jump_wrong), 32'd1);
    check("br_jpc", jump_pc, 32'h100);
    check("br_cv", 32'(commit_valid), 32'd0);
    check("br_ipos", 32'(issue_pos), 32'd0);
    idle(); issue(ROB_REG, 5'd7, 1'b0, 32'd0); alu(4'd1, 32'h9);
    tick();
    check("br_jw_fall", 32'(jump_wrong), 32'd0);
    check("br_issue_blocked", 32'(issue_pos), 32'd0);
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("br_no_commit", 32'(commit_valid), 32'd0);
    end

    // Correctly predicted branch commits silently
    issue(ROB_BR, 5'd0, 1'b1, 32'h200);
    tick();
    idle(); issue(ROB_REG, 5'd7, 1'b0, 32'd0); alu(4'd0, 32'd1);
    tick();
    idle(); alu(4'd1, 32'h5);
    tick();
    check("brok_jw", 32'(jump_wrong), 32'd0);
    check("brok_cv", 32'(commit_valid), 32'd0);
    idle();
    tick();
    check("brok_reg_cv", 32'(commit_valid), 32'd1);
    check("brok_reg_rd", 32'(commit_rd), 32'd7);
    check("brok_reg_val", commit_val, 32'h5);
    check("brok_reg_jw", 32'(jump_wrong), 32'd0);

    // JALR: link value committed and always redirects
    do_reset();
    issue(ROB_JALR, 5'd1, 1'b0, 32'h24);
    tick();
    idle(); alu(4'd0, 32'h80);
    tick();
    idle();
    tick();
    check("jalr_cv", 32'(commit_valid), 32'd1);
    check("jalr_rd", 32'(commit_rd), 32'd1);
    check("jalr_val", commit_val, 32'h24);
    check("jalr_jw", 32'(jump_wrong), 32'd1);
    check("jalr_jpc", jump_pc, 32'h80);
    tick();
    check("jalr_jw_fall", 32'(jump_wrong), 32'd0);
    check("jalr_cv_fall", 32'(commit_valid), 32'd0);

    // Query forwarding and stored lookup
    do_reset();
    for (int i = 0; i < 4; i++) begin
      idle(); issue(ROB_REG, 5'(i + 1), 1'b0, 32'd0);
      tick();
    end
    idle(); alu(4'd3, 32'h55); load(4'd2, 32'h66); q1 = 4'd3; q2 = 4'd2;
    #1;
    check("q_fwd_qr1", 32'(qr1), 32'd1);
    check("q_fwd_qv1", qv1, 32'h55);
    check("q_fwd_ld_qv2", qv2, 32'h66);
    tick();
    idle(); q2 = 4'd1;
    #1;
    check("q_stored_qr1", 32'(qr1), 32'd1);
    check("q_stored_qv1", qv1, 32'h55);
    check("q_unready_qr2", 32'(qr2), 32'd0);
    check("q_unready_qv2", qv2, 32'd0);

    // rdy low holds state; store commits on first cycle with rdy
    do_reset();
    issue(ROB_STORE, 5'd0, 1'b0, 32'd0);
    tick();
    idle(); st_v = 1'b1; st_pos = 4'd0;
    tick();
    idle(); rdy = 1'b0; issue(ROB_REG, 5'd4, 1'b0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_cs", 32'(commit_store), 32'd0);
      check("hold_ipos", 32'(issue_pos), 32'd1);
    end
    idle(); rdy = 1'b1;
    tick();
    check("st_commit", 32'(commit_store), 32'd1);
    check("st_pos", 32'(commit_ROB_pos), 32'd0);
    check("st_cv", 32'(commit_valid), 32'd0);
    tick();
    check("st_pulse_end", 32'(commit_store), 32'd0);

    // Reset mid-run wins over rdy low and a pending issue
    do_reset();
    issue(ROB_JALR, 5'd2, 1'b0, 32'h30);
    tick();
    idle(); alu(4'd0, 32'h90);
    tick();
    idle();
    tick();
    check("pre_rst_jw", 32'(jump_wrong), 32'd1);
    issue(ROB_REG, 5'd3, 1'b0, 32'd0); alu(4'd1, 32'h1);
    tick();
    idle(); issue(ROB_REG, 5'd3, 1'b0, 32'd0); rdy = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; rdy = 1'b1; idle(); q1 = 4'd0;
    #1;
    check_zero("midrst");
    check("midrst_qr1", 32'(qr1), 32'd0);
    tick();
    check("midrst_no_commit", 32'(commit_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
